// File: rtl/wght_mc_dispatch.sv
// ---------------------------------------------------------------------------
// wght_mc_dispatch
// Downstream stage of the weight-load controller. {tag, weight} pairs returned
// by the weight GLB are buffered in a small FIFO. The FIFO drains onto the
// PE-array multicast bus through a valid/ready handshake. A registered stall
// throttles the loader early enough to absorb the GLB returns still in
// flight. The block pulses done once every weight of the pass has gone out.
//
// Ports
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_pass_start              pulse in IDLE: latch pass size, arm delivery
//   i_layer_RS/_p/_q          pass geometry: words = p*q*RS*RS
//   i_glb_rvalid/_rdata       GLB return (write side of the FIFO)
//   i_wght_tag                multicast tag aligned with i_glb_rdata
//   o_wght_stall              loader must hold its read sequence
//   o_mc_valid/_data/_tag     multicast word, show-ahead from FIFO head
//   i_mc_ready                PE array accepts the word this cycle
//   o_pass_done               1-cycle pulse after the last word is accepted
//   o_ovf_err                 sticky: a returned word was lost to overflow
// ---------------------------------------------------------------------------
module wght_mc_dispatch #(
  parameter int DATA_W   = 16,
  parameter int TAG_W    = 8,
  parameter int DEPTH    = 8,
  parameter int AF_SLACK = 3
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_pass_start,
  input  logic [3:0]        i_layer_RS,
  input  logic [2:0]        i_layer_p,
  input  logic [2:0]        i_layer_q,
  input  logic              i_glb_rvalid,
  input  logic [DATA_W-1:0] i_glb_rdata,
  input  logic [TAG_W-1:0]  i_wght_tag,
  output logic              o_wght_stall,
  output logic              o_mc_valid,
  output logic [DATA_W-1:0] o_mc_data,
  output logic [TAG_W-1:0]  o_mc_tag,
  input  logic              i_mc_ready,
  output logic              o_pass_done,
  output logic              o_ovf_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = TAG_W + DATA_W;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] STALL_TH = CNT_W'(DEPTH - AF_SLACK);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t            state_q,    state_d;
  logic [PTR_W-1:0]  wr_ptr_q,   wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q,   rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q,      cnt_d;
  logic [15:0]       expected_q, expected_d;
  logic [15:0]       sent_cnt_q, sent_cnt_d;
  logic              stall_q,    stall_d;
  logic              ovf_q,      ovf_d;

  logic [ENT_W-1:0]  mem_q [DEPTH];
  logic [ENT_W-1:0]  head;
  logic              empty, full, mc_valid, pop, push;
  logic [15:0]       pass_words;

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == FULL_CNT);
  // A zero-size pass must not deliver leftovers buffered from earlier returns.
  assign mc_valid = (state_q == ST_RUN) && !empty && (expected_q != '0);
  assign pop      = mc_valid && i_mc_ready;
  // When full, a same-cycle pop frees the slot, so the push is still accepted.
  assign push     = i_glb_rvalid && (!full || pop);
  assign head     = mem_q[rd_ptr_q];

  assign pass_words = 16'(i_layer_p) * 16'(i_layer_q) * 16'(i_layer_RS) * 16'(i_layer_RS);

  // NOTE: storage has no reset; emptiness is tracked by cnt_q/pointers, so a
  // reset discards contents without clearing every entry.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= {i_wght_tag, i_glb_rdata};
  end

  always_comb begin
    // NOTE: every variable gets its hold value first so no path infers a latch.
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    expected_d = expected_q;
    sent_cnt_d = sent_cnt_q;
    ovf_d      = ovf_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);

    if (i_glb_rvalid && full && !pop) ovf_d = 1'b1;

    // Registered: asserts one cycle after the threshold is reached, which still
    // leaves room for the two GLB returns already in flight.
    stall_d = (cnt_q >= STALL_TH);

    unique case (state_q)
      ST_IDLE: begin
        if (i_pass_start) begin
          expected_d = pass_words;
          sent_cnt_d = '0;
          state_d    = ST_RUN;
        end
      end
      ST_RUN: begin
        if (expected_q == '0) begin
          state_d = ST_DONE;
        end else if (pop) begin
          sent_cnt_d = sent_cnt_q + 16'd1;
          if (sent_cnt_q == expected_q - 16'd1) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        sent_cnt_d = '0;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before the edge regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      expected_q <= '0;
      sent_cnt_q <= '0;
      stall_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      expected_q <= expected_d;
      sent_cnt_q <= sent_cnt_d;
      stall_q    <= stall_d;
      ovf_q      <= ovf_d;
    end
  end

  assign o_mc_valid   = mc_valid;
  // Bus is held at zero while idle so reset and empty cycles show a clean bus.
  assign o_mc_data    = mc_valid ? head[DATA_W-1:0] : '0;
  assign o_mc_tag     = mc_valid ? head[ENT_W-1:DATA_W] : '0;
  assign o_wght_stall = stall_q;
  assign o_pass_done  = (state_q == ST_DONE);
  assign o_ovf_err    = ovf_q;

endmodule
